// File: rtl/rob_mem_port.sv
// Memory-side responder for ROB commit traffic: byte-serial store writes and deferred IO loads.
// All bus outputs are registered; mem_busy is decoded from the state register.
module rob_mem_port #(
    parameter logic [31:0] IO_ADDR = 32'h00030000,
    parameter logic [1:0]  IO_HI   = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        if_out_mem,
    input  logic [5:0]  out_mem_size,
    input  logic [31:0] out_mem_addr,
    input  logic [31:0] out_mem_data,
    input  logic        if_out_mem_io,
    output logic        if_stored,
    output logic        if_get_mem,
    output logic [31:0] data_mem,
    output logic        mem_busy,
    input  logic [7:0]  mem_din,
    input  logic        io_buffer_full,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_IOLD_ADDR,
        S_IOLD_DATA,
        S_DONE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [31:0] r_data, w_data_nxt;
    logic [1:0]  r_cnt, w_cnt_nxt;
    logic [1:0]  r_last, w_last_nxt;
    logic [31:0] r_mem_a, w_mem_a_nxt;
    logic [7:0]  r_mem_dout, w_mem_dout_nxt;
    logic        r_mem_wr, w_mem_wr_nxt;
    logic        r_stored, w_stored_nxt;
    logic        r_get, w_get_nxt;
    logic [31:0] r_data_mem, w_data_mem_nxt;

    logic        w_hold;
    logic [31:0] w_shifted;

    // Stores into the IO region stall while the IO output buffer is full.
    assign w_hold    = (r_addr[17:16] == IO_HI) && io_buffer_full;
    assign w_shifted = r_data >> {r_cnt, 3'b000};

    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_cnt_nxt      = r_cnt;
        w_last_nxt     = r_last;
        w_mem_a_nxt    = r_mem_a;
        w_mem_dout_nxt = r_mem_dout;
        w_mem_wr_nxt   = 1'b0;
        w_stored_nxt   = 1'b0;
        w_get_nxt      = 1'b0;
        w_data_mem_nxt = r_data_mem;
        case (r_state)
            S_IDLE: begin
                if (!clear) begin
                    if (if_out_mem) begin
                        w_addr_nxt  = out_mem_addr;
                        w_data_nxt  = out_mem_data;
                        w_cnt_nxt   = '0;
                        w_last_nxt  = (out_mem_size == 6'd1) ? 2'd0 :
                                      (out_mem_size == 6'd2) ? 2'd1 : 2'd3;
                        w_state_nxt = S_STORE;
                    end else if (if_out_mem_io) begin
                        w_mem_a_nxt = IO_ADDR;
                        w_state_nxt = S_IOLD_ADDR;
                    end
                end
            end
            S_STORE: begin
                if (!w_hold) begin
                    w_mem_a_nxt    = r_addr + {30'b0, r_cnt};
                    w_mem_dout_nxt = w_shifted[7:0];
                    w_mem_wr_nxt   = 1'b1;
                    w_cnt_nxt      = r_cnt + 2'd1;
                    if (r_cnt == r_last)
                        w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_stored_nxt = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            S_IOLD_ADDR: begin
                w_state_nxt = clear ? S_IDLE : S_IOLD_DATA;
            end
            S_IOLD_DATA: begin
                if (!clear) begin
                    w_data_mem_nxt = {24'b0, mem_din};
                    w_get_nxt      = 1'b1;
                end
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_data     <= '0;
            r_cnt      <= '0;
            r_last     <= '0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_mem_wr   <= 1'b0;
            r_stored   <= 1'b0;
            r_get      <= 1'b0;
            r_data_mem <= '0;
        end else if (!rdy) begin
            // Freeze: everything holds except the write strobe, so no byte is written twice.
            r_mem_wr <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last     <= w_last_nxt;
            r_mem_a    <= w_mem_a_nxt;
            r_mem_dout <= w_mem_dout_nxt;
            r_mem_wr   <= w_mem_wr_nxt;
            r_stored   <= w_stored_nxt;
            r_get      <= w_get_nxt;
            r_data_mem <= w_data_mem_nxt;
        end
    end

    assign if_stored  = r_stored;
    assign if_get_mem = r_get;
    assign data_mem   = r_data_mem;
    assign mem_a      = r_mem_a;
    assign mem_dout   = r_mem_dout;
    assign mem_wr     = r_mem_wr;
    assign mem_busy   = (r_state != S_IDLE);

endmodule
